mem_io_responder: RTL

- Memory-side responder for the CPU's byte-wide memory bus: the address, write data and write enable coming out of the CPU, the read data going back in, and the I/O-buffer-full indication.
- Contains the 128 KB RAM and the memory-mapped I/O at 0x30000/0x30004: UART TX/RX byte FIFOs, a free-running cycle counter and a program-stop flag.
- Sits outside the CPU, between the CPU core and the UART/host-side logic.

---
 rtl/mem_io_responder.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 128 KB RAM plus memory-mapped I/O
// (UART TX/RX byte FIFOs, free-running cycle counter, program-stop flag).
module mem_io_responder #(
  parameter int unsigned RAM_ADDR_W  = 17,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  localparam int unsigned RamWords = 2 ** RAM_ADDR_W;
  localparam int unsigned TxPw     = $clog2(TX_DEPTH);
  localparam int unsigned TxCw     = TxPw + 1;
  localparam int unsigned RxPw     = $clog2(RX_DEPTH);
  localparam int unsigned RxCw     = RxPw + 1;

  localparam logic [TxCw-1:0] TxDepthC  = TxCw'(TX_DEPTH);
  localparam logic [TxCw-1:0] TxFullLvl = TxCw'(TX_DEPTH - FULL_MARGIN);
  localparam logic [RxCw-1:0] RxDepthC  = RxCw'(RX_DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic                  io_sel;
  logic                  io_data;
  logic                  io_cnt;
  logic                  io_stop;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  unused_addr;

  assign io_sel      = (mem_a[17:16] == 2'b11);
  assign io_data     = io_sel && (mem_a[15:0] == 16'h0000);
  assign io_cnt      = io_sel && (mem_a[15:2] == 14'h0001);
  assign io_stop     = io_cnt && (mem_a[1:0] == 2'b00);
  assign ram_idx     = mem_a[RAM_ADDR_W-1:0];
  // Upper address bits do not participate in decode; addresses alias.
  assign unused_addr = ^mem_a[31:18];

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [7:0] ram [RamWords];
  logic [7:0] ram_rdata_q;

  // Synchronous write and registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (!io_sel && mem_wr) begin
      ram[ram_idx] <= mem_wdata;
    end
    ram_rdata_q <= ram[ram_idx];
  end

  // ---------------------------------------------------------------------------
  // TX FIFO (CPU -> UART)
  // ---------------------------------------------------------------------------
  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TxPw-1:0] tx_rd_q;
  logic [TxPw-1:0] tx_wr_q;
  logic [TxCw-1:0] tx_cnt_q;
  logic            tx_full;
  logic            tx_pop;
  logic            tx_push_req;
  logic            tx_push;
  logic            tx_drop;
  logic [7:0]      tx_push_byte;

  assign tx_valid       = (tx_cnt_q != '0);
  assign tx_data        = tx_mem[tx_rd_q];
  assign tx_full        = (tx_cnt_q == TxDepthC);
  assign tx_pop         = tx_valid && tx_ready;
  // A write to the stop register enqueues a NUL so the host sees end-of-output.
  assign tx_push_req    = mem_wr && ((io_data && (mem_wdata != 8'h00)) || io_stop);
  assign tx_push_byte   = io_stop ? 8'h00 : mem_wdata;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign tx_push        = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop        = tx_push_req && tx_full && !tx_pop;
  assign io_buffer_full = (tx_cnt_q >= TxFullLvl);

  // TX storage write port.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_q] <= tx_push_byte;
    end
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TxPw'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + TxPw'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + TxCw'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - TxCw'(1);
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (UART -> CPU)
  // ---------------------------------------------------------------------------
  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RxPw-1:0] rx_rd_q;
  logic [RxPw-1:0] rx_wr_q;
  logic [RxCw-1:0] rx_cnt_q;
  logic            rx_empty;
  logic            rx_pop;
  logic            rx_push;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_pop   = io_data && !mem_wr && !rx_empty;
  // A CPU pop in the same cycle makes room, so push and pop both proceed when full.
  assign rx_ready = (rx_cnt_q != RxDepthC) || rx_pop;
  assign rx_push  = rx_valid && rx_ready;

  // RX storage write port.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_q] <= rx_data;
    end
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + RxPw'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + RxPw'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + RxCw'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - RxCw'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // I/O read data, cycle counter, status flags
  // ---------------------------------------------------------------------------
  logic [31:0] cyc_q;
  logic [23:0] snap_q;      // bytes 1..3 of the snapshot; byte 0 is read live
  logic        sel_ram_q;
  logic [7:0]  io_rdata_q;
  logic [7:0]  io_rdata_d;

  // Next I/O read byte for the current request.
  always_comb begin
    io_rdata_d = 8'h00;
    if (!mem_wr) begin
      if (io_data && !rx_empty) begin
        io_rdata_d = rx_mem[rx_rd_q];
      end else if (io_cnt) begin
        unique case (mem_a[1:0])
          2'b00: io_rdata_d = cyc_q[7:0];
          2'b01: io_rdata_d = snap_q[7:0];
          2'b10: io_rdata_d = snap_q[15:8];
          2'b11: io_rdata_d = snap_q[23:16];
        endcase
      end
    end
  end

  // Counter, snapshot, read-source select and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q       <= '0;
      snap_q      <= '0;
      sel_ram_q   <= 1'b0;
      io_rdata_q  <= '0;
      prog_stop   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      cyc_q      <= cyc_q + 32'd1;
      sel_ram_q  <= !io_sel;
      io_rdata_q <= io_rdata_d;
      if (io_stop && !mem_wr) snap_q      <= cyc_q[31:8];
      if (io_stop && mem_wr)  prog_stop   <= 1'b1;
      if (tx_drop)            tx_overflow <= 1'b1;
    end
  end

  assign mem_rdata = sel_ram_q ? ram_rdata_q : io_rdata_q;

endmodule
